uart_fnd_scan_ctrl: RTL

//  Controller between the UART receiver and a single shared FND decoder.
//  - Captures each received byte on the receiver done strobe into a small

---
 rtl/uart_fnd_scan_ctrl_pkg.sv | 22 ++
 rtl/uart_fnd_scan_ctrl_if.sv | 23 ++
 rtl/fnd_scan_timer.sv | 35 +++
 rtl/uart_fnd_scan_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/uart_fnd_scan_ctrl_pkg.sv
// rtl/uart_fnd_scan_ctrl_pkg.sv - shared constants and width helpers for the FND scan controller
package uart_fnd_scan_ctrl_pkg;

  localparam logic [7:0] CLR_CODE_DEF   = 8'h1B;
  localparam int         SCAN_DIV_DEF   = 50000;
  localparam int         NUM_BYTES_DEF  = 2;
  localparam int         NUM_DIGITS_DEF = 2 * NUM_BYTES_DEF;

  function automatic int num_digits(input int num_bytes);
    return 2 * num_bytes;
  endfunction

  // Never returns less than 1 so single-entry counters still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_fnd_scan_ctrl_if.sv
// rtl/uart_fnd_scan_ctrl_if.sv - receiver byte input and scanned display output bundle
interface uart_fnd_scan_ctrl_if #(
  parameter int NUM_BYTES = 2
) ();

  logic                   i_fDone;
  logic [7:0]             i_RxData;
  logic [3:0]             o_Nibble;
  logic                   o_Blank;
  logic [2*NUM_BYTES-1:0] o_DigitSel;
  logic [7:0]             o_ByteCnt;

  modport master (
    output i_fDone, i_RxData,
    input  o_Nibble, o_Blank, o_DigitSel, o_ByteCnt
  );

  modport slave (
    input  i_fDone, i_RxData,
    output o_Nibble, o_Blank, o_DigitSel, o_ByteCnt
  );

endinterface

// File: rtl/fnd_scan_timer.sv
// rtl/fnd_scan_timer.sv - digit dwell prescaler and wrapping digit index
module fnd_scan_timer
  import uart_fnd_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int IW         = clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          adv
);

  localparam int            CW       = clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;

  assign adv = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (adv) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fnd_scan_ctrl.sv
// rtl/uart_fnd_scan_ctrl.sv - captures UART bytes into a history buffer and scans its nibbles onto one FND decoder
module uart_fnd_scan_ctrl
  import uart_fnd_scan_ctrl_pkg::*;
#(
  parameter int         NUM_BYTES   = NUM_BYTES_DEF,
  parameter int         SCAN_DIV    = SCAN_DIV_DEF,
  parameter logic [7:0] CLR_CODE    = CLR_CODE_DEF,
  parameter bit         SEL_ACT_LOW = 1'b1
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  uart_fnd_scan_ctrl_if.slave bus
);

  localparam int            ND      = num_digits(NUM_BYTES);
  localparam int            IW      = clog2(ND);
  localparam logic [ND-1:0] SEL_ONE = ND'(1);
  localparam logic [ND-1:0] SEL_RST = SEL_ACT_LOW ? ~SEL_ONE : SEL_ONE;

  logic [IW-1:0]          idx;
  logic                   scan_adv;
  logic                   fdone_q;
  logic                   byte_evt;
  logic [8*NUM_BYTES-1:0] buf_q;
  logic [NUM_BYTES-1:0]   valid_q;
  logic [ND-1:0]          valid_dig;
  logic [ND-1:0]          sel_onehot;
  logic [7:0]             byte_cnt;

  fnd_scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (ND),
    .IW         (IW)
  ) u_timer (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .idx   (idx),
    .adv   (scan_adv)
  );

  assign byte_evt      = bus.i_fDone & ~fdone_q;
  assign bus.o_ByteCnt = byte_cnt;

  always_comb begin
    valid_dig = '0;
    for (int d = 0; d < ND; d++) valid_dig[d] = valid_q[d/2];
  end

  // Outputs sample pre-edge state so select, nibble and blank always change together.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      fdone_q        <= 1'b0;
      buf_q          <= '0;
      valid_q        <= '0;
      byte_cnt       <= '0;
      sel_onehot     <= SEL_ONE;
      bus.o_Nibble   <= 4'h0;
      bus.o_Blank    <= 1'b1;
      bus.o_DigitSel <= SEL_RST;
    end else begin
      fdone_q <= bus.i_fDone;
      if (byte_evt) begin
        if (bus.i_RxData == CLR_CODE) begin
          buf_q    <= '0;
          valid_q  <= '0;
          byte_cnt <= '0;
        end else begin
          for (int k = NUM_BYTES - 1; k > 0; k--) begin
            buf_q[8*k +: 8] <= buf_q[8*(k-1) +: 8];
            valid_q[k]      <= valid_q[k-1];
          end
          buf_q[7:0] <= bus.i_RxData;
          valid_q[0] <= 1'b1;
          if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 1'b1;
        end
      end
      if (scan_adv) sel_onehot <= {sel_onehot[ND-2:0], sel_onehot[ND-1]};
      bus.o_Nibble   <= buf_q[{idx, 2'b00} +: 4];
      bus.o_Blank    <= ~valid_dig[idx];
      bus.o_DigitSel <= SEL_ACT_LOW ? ~sel_onehot : sel_onehot;
    end
  end

endmodule
